arm_mc_controller: RTL and testbench

Multicycle control unit for the ARM-subset processor: a Moore FSM that sequences fetch, decode, memory and execute steps over the shared ALU, register file and unified memory. Holds the NZCV flags register, evaluates the instruction condition field, and gates every architectural write strobe with the result. Sits beside the datapath; it consumes instruction fields and ALU flags and drives all mux selects, enables and the 2-bit ALU operation.

---
 rtl/arm_mc_pkg.sv | 52 +++++
 rtl/arm_cond_unit.sv | 51 +++++
 rtl/arm_mc_controller.sv | 142 ++++++++++++++
 tb/tb_arm_mc_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath select codes, ALU operations, opcode classes and condition codes.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UNS = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flags register and condition-field evaluation. CondEx looks only at the
// registered flags, so ALUFlags never reaches an output combinationally.
module arm_cond_unit
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    output logic       CondEx
);

    logic [3:0] flags_q;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z_f;
            COND_NE: CondEx = ~z_f;
            COND_CS: CondEx = c_f;
            COND_CC: CondEx = ~c_f;
            COND_MI: CondEx = n_f;
            COND_PL: CondEx = ~n_f;
            COND_VS: CondEx = v_f;
            COND_VC: CondEx = ~v_f;
            COND_HI: CondEx = c_f & ~z_f;
            COND_LS: CondEx = ~c_f | z_f;
            COND_GE: CondEx = (n_f == v_f);
            COND_LT: CondEx = (n_f != v_f);
            COND_GT: CondEx = ~z_f & (n_f == v_f);
            COND_LE: CondEx = z_f | (n_f != v_f);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // NZ and CV update independently so logical ops preserve carry/overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else begin
            if (FlagW[1] & CondEx) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & CondEx) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle Moore control FSM: sequences fetch/decode/memory/execute over a
// shared datapath and gates every architectural write with the condition result.
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    state_e     state_q, state_d;
    logic       reg_w, mem_w, branch, ir_w, alu_dec;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       pcs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        ir_w      = 1'b0;
        alu_dec   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                ir_w      = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_UNS:  state_d = S_FETCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_dec = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_dec = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU decode only in the execute states; unknown commands fall back to a
    // flag-preserving ADD.
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_dec) begin
            case (Funct[4:1])
                4'b0100: begin ALUControl = ALU_ADD; flag_w = {2{Funct[0]}}; end
                4'b0010: begin ALUControl = ALU_SUB; flag_w = {2{Funct[0]}}; end
                4'b0000: begin ALUControl = ALU_AND; flag_w = {Funct[0], 1'b0}; end
                4'b1100: begin ALUControl = ALU_ORR; flag_w = {Funct[0], 1'b0}; end
                default: begin ALUControl = ALU_ADD; flag_w = 2'b00; end
            endcase
        end
    end

    arm_cond_unit u_cond (
        .clk      (clk),
        .reset_n  (reset_n),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .CondEx   (cond_ex)
    );

    assign pcs      = branch | (reg_w & (Rd == 4'b1111));
    assign PCWrite  = reset_n & ((state_q == S_FETCH) | (pcs & cond_ex));
    assign MemWrite = reset_n & mem_w & cond_ex;
    assign RegWrite = reset_n & reg_w & cond_ex;
    assign IRWrite  = reset_n & ir_w;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: walks instruction classes cycle by cycle
// and compares the packed control word against hand-derived values.
module tb_arm_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    logic [11:0] sig;
    assign sig = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [11:0] sg(input logic pcw, input logic mw, input logic rw,
                                       input logic irw, input logic adr, input logic a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [1:0] alu);
        return {pcw, mw, rw, irw, adr, a, b, rs, alu};
    endfunction

    // Strobe-free FETCH selects, as seen while reset_n is low.
    localparam logic [11:0] SIG_F   = 12'b1001_0110_1000;
    localparam logic [11:0] SIG_D   = 12'b0000_0110_1000;
    localparam logic [11:0] SIG_RST = 12'b0000_0110_1000;

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] fl);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [11:0] exp);
        @(negedge clk);
        check(tag, {4'h0, sig}, {4'h0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_instr(4'hE, 2'b00, 6'b001001, 4'h1, 4'b0110);
        #3;
        check("reset_sig", {4'h0, sig}, {4'h0, SIG_RST});
        check("reset_flags", {12'h0, dut.u_cond.flags_q}, 16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ADDS R1,R2,R3 with ALUFlags=0110
        step("adds_fetch", SIG_F);
        step("adds_decode", SIG_D);
        step("adds_execr", sg(0,0,0,0,0,0,2'b00,2'b00,2'b00));
        step("adds_aluwb", sg(0,0,1,0,0,0,2'b00,2'b00,2'b00));
        check("adds_flags", {12'h0, dut.u_cond.flags_q}, 16'h0006);

        // ANDS immediate, ALUFlags=1011: NZ <- 10, CV keep 10
        set_instr(4'hE, 2'b00, 6'b100001, 4'h3, 4'b1011);
        step("ands_fetch", SIG_F);
        step("ands_decode", SIG_D);
        step("ands_execi", sg(0,0,0,0,0,0,2'b01,2'b00,2'b10));
        step("ands_aluwb", sg(0,0,1,0,0,0,2'b00,2'b00,2'b00));
        check("ands_flags", {12'h0, dut.u_cond.flags_q}, 16'h000A);

        // LDR
        set_instr(4'hE, 2'b01, 6'b011001, 4'h2, 4'b0000);
        step("ldr_fetch", SIG_F);
        check("ldr_imm_regsrc", {12'h0, ImmSrc, RegSrc}, 16'h0006);
        step("ldr_decode", SIG_D);
        step("ldr_memadr", sg(0,0,0,0,0,0,2'b01,2'b00,2'b00));
        step("ldr_memrd", sg(0,0,0,0,1,0,2'b00,2'b00,2'b00));
        step("ldr_memwb", sg(0,0,1,0,0,0,2'b00,2'b01,2'b00));

        // STR
        set_instr(4'hE, 2'b01, 6'b011000, 4'h2, 4'b0000);
        step("str_fetch", SIG_F);
        step("str_decode", SIG_D);
        step("str_memadr", sg(0,0,0,0,0,0,2'b01,2'b00,2'b00));
        step("str_memwr", sg(0,1,0,0,1,0,2'b00,2'b00,2'b00));

        // BEQ with Z=0 (flags 1010)
        set_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
        step("beq_nt_fetch", SIG_F);
        check("br_imm_regsrc", {12'h0, ImmSrc, RegSrc}, 16'h0009);
        step("beq_nt_decode", SIG_D);
        step("beq_nt_branch", sg(0,0,0,0,0,0,2'b01,2'b10,2'b00));

        // ORRS reg, ALUFlags=0100 -> flags 0110 (Z set, C kept)
        set_instr(4'hE, 2'b00, 6'b011001, 4'h4, 4'b0100);
        step("orrs_fetch", SIG_F);
        step("orrs_decode", SIG_D);
        step("orrs_execr", sg(0,0,0,0,0,0,2'b00,2'b00,2'b11));
        step("orrs_aluwb", sg(0,0,1,0,0,0,2'b00,2'b00,2'b00));
        check("orrs_flags", {12'h0, dut.u_cond.flags_q}, 16'h0006);

        // BEQ with Z=1
        set_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
        step("beq_t_fetch", SIG_F);
        step("beq_t_decode", SIG_D);
        step("beq_t_branch", sg(1,0,0,0,0,0,2'b01,2'b10,2'b00));

        // ADD PC,..., Cond=AL
        set_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'b1111);
        step("addpc_fetch", SIG_F);
        step("addpc_decode", SIG_D);
        step("addpc_execr", sg(0,0,0,0,0,0,2'b00,2'b00,2'b00));
        step("addpc_aluwb", sg(1,0,1,0,0,0,2'b00,2'b00,2'b00));
        check("addpc_flags", {12'h0, dut.u_cond.flags_q}, 16'h0006);

        // ADDS PC,..., Cond=1111: nothing written, flags kept
        set_instr(4'hF, 2'b00, 6'b001001, 4'hF, 4'b1111);
        step("nv_fetch", SIG_F);
        step("nv_decode", SIG_D);
        step("nv_execr", sg(0,0,0,0,0,0,2'b00,2'b00,2'b00));
        step("nv_aluwb", sg(0,0,0,0,0,0,2'b00,2'b00,2'b00));
        check("nv_flags", {12'h0, dut.u_cond.flags_q}, 16'h0006);

        // SUBS NE with Z=1: suppressed
        set_instr(4'h1, 2'b00, 6'b000101, 4'h5, 4'b1001);
        step("subne_fetch", SIG_F);
        step("subne_decode", SIG_D);
        step("subne_execr", sg(0,0,0,0,0,0,2'b00,2'b00,2'b01));
        step("subne_aluwb", sg(0,0,0,0,0,0,2'b00,2'b00,2'b00));
        check("subne_flags", {12'h0, dut.u_cond.flags_q}, 16'h0006);

        // SUBS GE (N==V): executes, flags <- 1001
        set_instr(4'hA, 2'b00, 6'b000101, 4'h5, 4'b1001);
        step("subge_fetch", SIG_F);
        step("subge_decode", SIG_D);
        step("subge_execr", sg(0,0,0,0,0,0,2'b00,2'b00,2'b01));
        step("subge_aluwb", sg(0,0,1,0,0,0,2'b00,2'b00,2'b00));
        check("subge_flags", {12'h0, dut.u_cond.flags_q}, 16'h0009);

        // Op=11 is a two-cycle NOP
        set_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000);
        step("nop_fetch", SIG_F);
        step("nop_decode", SIG_D);

        // Reset asserted mid-EXECR, checked before any clock edge
        set_instr(4'hE, 2'b00, 6'b001001, 4'h1, 4'b0110);
        step("rst_add_fetch", SIG_F);
        step("rst_add_decode", SIG_D);
        reset_n = 1'b0;
        #2;
        check("midrst_sig", {4'h0, sig}, {4'h0, SIG_RST});
        check("midrst_flags", {12'h0, dut.u_cond.flags_q}, 16'h0000);
        @(posedge clk); #1;
        check("midrst_hold", {4'h0, sig}, {4'h0, SIG_RST});
        reset_n = 1'b1;
        set_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000);
        step("post_rst_fetch", SIG_F);
        step("post_rst_decode", SIG_D);
        step("post_rst_fetch2", SIG_F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
